// File: rtl/vga_sync_monitor.sv
// VGA sync monitor: measures line/frame timing, locks onto a stable raster,
// streams active pixels and reports a per-frame checksum and error counts.
module vga_sync_monitor #(
    parameter int H_TOTAL  = 800,
    parameter int H_START  = 144,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int V_START  = 35,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        Hsync,
    input  logic        Vsync,
    input  logic [7:0]  ColorIn,
    output logic        locked,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [7:0]  pix_data,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic        h_err,
    output logic        v_err,
    output logic [7:0]  err_cnt
);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FIRST = 10'(H_START);
    localparam logic [9:0] H_END   = 10'(H_START + H_ACTIVE - 1);
    localparam logic [9:0] V_LINES = 10'(V_TOTAL);
    localparam logic [9:0] V_FIRST = 10'(V_START);
    localparam logic [9:0] V_END   = 10'(V_START + V_ACTIVE - 1);
    localparam logic [9:0] CNT_MAX = 10'h3FF;

    typedef enum logic [1:0] { ST_HUNT, ST_ACQ, ST_LOCK } state_e;

    state_e      state_q, state_d;
    logic        hs_q, hs_d, hs_p_q, hs_p_d;
    logic        vs_q, vs_d, vs_p_q, vs_p_d;
    logic [7:0]  col_q, col_d;
    logic        en_q, en_d;
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        herr_seen_q, herr_seen_d;
    logic [15:0] acc_q, acc_d;
    logic        pix_valid_q, pix_valid_d;
    logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [7:0]  pix_data_q, pix_data_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_sum_q, frame_sum_d;
    logic        h_err_q, h_err_d, v_err_q, v_err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        h_fall, v_fall, active, frame_bad;

    assign locked     = (state_q == ST_LOCK);
    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_data   = pix_data_q;
    assign frame_done = frame_done_q;
    assign frame_sum  = frame_sum_q;
    assign h_err      = h_err_q;
    assign v_err      = v_err_q;
    assign err_cnt    = err_cnt_q;

    // Input sampling; en_q marks the clk after a fresh sample is taken.
    always_comb begin
        hs_d   = hs_q;
        vs_d   = vs_q;
        col_d  = col_q;
        hs_p_d = hs_p_q;
        vs_p_d = vs_p_q;
        en_d   = pix_en;
        if (pix_en) begin
            hs_d   = Hsync;
            vs_d   = Vsync;
            col_d  = ColorIn;
            hs_p_d = hs_q;
            vs_p_d = vs_q;
        end
    end

    // Position counters; v_cnt doubles as the frame line counter.
    always_comb begin
        h_fall  = en_q & hs_p_q & ~hs_q;
        v_fall  = en_q & vs_p_q & ~vs_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (en_q) begin
            if (h_fall)
                h_cnt_d = '0;
            else if (h_cnt_q != CNT_MAX)
                h_cnt_d = h_cnt_q + 10'd1;
            if (v_fall)
                v_cnt_d = {9'd0, h_fall};
            else if (h_fall && v_cnt_q != CNT_MAX)
                v_cnt_d = v_cnt_q + 10'd1;
        end
        h_err_d = h_fall && (state_q != ST_HUNT) && (h_cnt_q != H_LAST);
        herr_seen_d = v_fall ? 1'b0 : (herr_seen_q | h_err_d);
        active = (h_cnt_d >= H_FIRST) && (h_cnt_d <= H_END) &&
                 (v_cnt_d >= V_FIRST) && (v_cnt_d <= V_END);
    end

    // Next-state logic, evaluated at every Vsync falling edge.
    always_comb begin
        frame_bad = herr_seen_q | h_err_d | (v_cnt_q != V_LINES);
        state_d   = state_q;
        if (v_fall) begin
            unique case (state_q)
                ST_HUNT: state_d = ST_ACQ;
                ST_ACQ:  state_d = frame_bad ? ST_ACQ : ST_LOCK;
                ST_LOCK: state_d = frame_bad ? ST_HUNT : ST_LOCK;
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // FSM outputs: frame verdict pulses.
    always_comb begin
        v_err_d      = v_fall && (state_q != ST_HUNT) && frame_bad;
        frame_done_d = v_fall && (state_q == ST_LOCK) && !frame_bad;
    end

    // Pixel stream, checksum and error counter.
    always_comb begin
        acc_d       = acc_q;
        frame_sum_d = frame_sum_q;
        pix_valid_d = 1'b0;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_data_d  = pix_data_q;
        err_cnt_d   = err_cnt_q;
        if (en_q) begin
            if (v_fall)
                acc_d = '0;
            else if (state_q != ST_HUNT && active)
                acc_d = acc_q + {8'h00, col_q};
            if (frame_done_d)
                frame_sum_d = acc_q;
            if (state_q == ST_LOCK && active) begin
                pix_valid_d = 1'b1;
                pix_x_d     = h_cnt_d - H_FIRST;
                pix_y_d     = v_cnt_d - V_FIRST;
                pix_data_d  = col_q;
            end
        end
        if ((h_err_d | v_err_d) && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
    end

    // State register; sync samples idle high so reset creates no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            hs_q         <= 1'b1;
            hs_p_q       <= 1'b1;
            vs_q         <= 1'b1;
            vs_p_q       <= 1'b1;
            col_q        <= '0;
            en_q         <= 1'b0;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            herr_seen_q  <= 1'b0;
            acc_q        <= '0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_data_q   <= '0;
            frame_done_q <= 1'b0;
            frame_sum_q  <= '0;
            h_err_q      <= 1'b0;
            v_err_q      <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            hs_q         <= hs_d;
            hs_p_q       <= hs_p_d;
            vs_q         <= vs_d;
            vs_p_q       <= vs_p_d;
            col_q        <= col_d;
            en_q         <= en_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            herr_seen_q  <= herr_seen_d;
            acc_q        <= acc_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_data_q   <= pix_data_d;
            frame_done_q <= frame_done_d;
            frame_sum_q  <= frame_sum_d;
            h_err_q      <= h_err_d;
            v_err_q      <= v_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Testbench for vga_sync_monitor: small raster, random pacing and colour,
// scoreboard of expected pixels and pulse events from a reference model.
module tb_vga_sync_monitor;
    localparam int HT = 24, HS = 5, HA = 16;
    localparam int VT = 10, VS = 2, VA = 6;

    logic        clk = 1'b0;
    logic        rst, pix_en, Hsync, Vsync;
    logic [7:0]  ColorIn;
    logic        locked, pix_valid, frame_done, h_err, v_err;
    logic [9:0]  pix_x, pix_y;
    logic [7:0]  pix_data, err_cnt;
    logic [15:0] frame_sum;

    vga_sync_monitor #(
        .H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_START(VS), .V_ACTIVE(VA)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .Hsync(Hsync), .Vsync(Vsync), .ColorIn(ColorIn),
        .locked(locked), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .frame_done(frame_done), .frame_sum(frame_sum),
        .h_err(h_err), .v_err(v_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errs = 0;

    function automatic void chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    typedef struct {
        int cyc; int x; int y; int d;
    } pix_t;
    typedef struct {
        int cyc; int he; int ve; int fd; int err; int fsum; int lk;
    } evt_t;

    pix_t pq[$];
    evt_t eq[$];

    // Reference model: raster rules stated on plain integers.
    // m_st: 0 hunting, 1 acquiring, 2 locked.
    int m_hp, m_vp, m_h, m_v, m_st, m_herrs, m_acc, m_err, m_fsum;

    task automatic model_reset();
        m_hp = 1; m_vp = 1; m_h = 0; m_v = 0; m_st = 0;
        m_herrs = 0; m_acc = 0; m_err = 0; m_fsum = 0;
    endtask

    task automatic model_sample(int hs, int vs, int c);
        int hf, vf, pre_h, pre_v, herr, verr, fd, bad, act;
        hf = (m_hp == 1 && hs == 0) ? 1 : 0;
        vf = (m_vp == 1 && vs == 0) ? 1 : 0;
        pre_h = m_h;
        pre_v = m_v;
        m_hp = hs;
        m_vp = vs;
        verr = 0;
        fd = 0;
        m_h = hf ? 0 : (m_h < 1023 ? m_h + 1 : 1023);
        if (vf) m_v = hf;
        else if (hf) m_v = (m_v < 1023) ? m_v + 1 : 1023;
        herr = (hf && m_st != 0 && pre_h != HT - 1) ? 1 : 0;
        m_herrs += herr;
        act = (m_h >= HS && m_h < HS + HA && m_v >= VS && m_v < VS + VA) ? 1 : 0;
        if (act && m_st == 2) pq.push_back('{cyc + 2, m_h - HS, m_v - VS, c});
        if (vf) begin
            bad = (m_herrs > 0 || pre_v != VT) ? 1 : 0;
            if (m_st == 0) m_st = 1;
            else if (m_st == 1) begin
                if (bad) verr = 1; else m_st = 2;
            end else begin
                if (bad) begin verr = 1; m_st = 0; end
                else begin fd = 1; m_fsum = m_acc; end
            end
            m_acc = 0;
            m_herrs = 0;
        end else if (act && m_st != 0) begin
            m_acc = (m_acc + c) % 65536;
        end
        if (herr || verr) m_err = (m_err < 255) ? m_err + 1 : 255;
        if (herr || verr || fd)
            eq.push_back('{cyc + 2, herr, verr, fd, m_err, m_fsum, (m_st == 2) ? 1 : 0});
    endtask

    // Monitor: every presented output is matched against the scoreboard.
    int pv_cnt = 0, last_x = -1, last_y = -1;
    always @(negedge clk) begin
        if (!rst) begin
            if (pix_valid) begin
                pv_cnt++;
                last_x = int'(pix_x);
                last_y = int'(pix_y);
                if (pq.size() == 0) chk("pix_unexpected", 1, 0);
                else begin
                    pix_t e;
                    e = pq.pop_front();
                    chk("pix_latency", cyc, e.cyc);
                    chk("pix_x", int'(pix_x), e.x);
                    chk("pix_y", int'(pix_y), e.y);
                    chk("pix_data", int'(pix_data), e.d);
                end
            end
            if (h_err || v_err || frame_done) begin
                if (eq.size() == 0) chk("pulse_unexpected", 1, 0);
                else begin
                    evt_t v;
                    v = eq.pop_front();
                    chk("evt_cycle", cyc, v.cyc);
                    chk("h_err", int'(h_err), v.he);
                    chk("v_err", int'(v_err), v.ve);
                    chk("frame_done", int'(frame_done), v.fd);
                    chk("err_cnt", int'(err_cnt), v.err);
                    chk("frame_sum", int'(frame_sum), v.fsum);
                    chk("evt_locked", int'(locked), v.lk);
                end
            end
        end
    end

    task automatic tick(int hs, int vs, int c);
        @(negedge clk);
        pix_en = 1'b1;
        Hsync = hs[0];
        Vsync = vs[0];
        ColorIn = 8'(c);
        model_sample(hs, vs, c);
        @(negedge clk);
        pix_en = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
    endtask

    // One frame: Vsync low on line 0, Hsync low on the first two pixels.
    task automatic frame(int nl, int short_ln, int formula);
        for (int ln = 0; ln < nl; ln++) begin
            int len;
            len = (ln == short_ln) ? HT - 1 : HT;
            for (int px = 0; px < len; px++)
                tick((px >= 2) ? 1 : 0, (ln >= 1) ? 1 : 0,
                     formula ? (px + ln + 1) % 256 : int'($urandom_range(0, 255)));
        end
    endtask

    task automatic settle(string tag);
        repeat (3) @(negedge clk);
        chk({tag, "_pix_drained"}, pq.size(), 0);
        chk({tag, "_evt_drained"}, eq.size(), 0);
        chk({tag, "_locked"}, int'(locked), (m_st == 2) ? 1 : 0);
        chk({tag, "_err_cnt"}, int'(err_cnt), m_err);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_pix_valid"}, int'(pix_valid), 0);
        chk({tag, "_pix_x"}, int'(pix_x), 0);
        chk({tag, "_pix_y"}, int'(pix_y), 0);
        chk({tag, "_pix_data"}, int'(pix_data), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_frame_sum"}, int'(frame_sum), 0);
        chk({tag, "_h_err"}, int'(h_err), 0);
        chk({tag, "_v_err"}, int'(v_err), 0);
        chk({tag, "_err_cnt"}, int'(err_cnt), 0);
    endtask

    initial begin
        rst = 1'b0;
        pix_en = 1'b0;
        Hsync = 1'b1;
        Vsync = 1'b1;
        ColorIn = '0;
        model_reset();
        #2 rst = 1'b1;
        #1 check_zero("rst0");
        repeat (3) @(negedge clk);
        check_zero("rst0_hold");
        rst = 1'b0;

        // Nominal acquisition: lock after edge 2, frame_done from edge 3.
        pv_cnt = 0;
        frame(VT, -1, 1);
        settle("acq");
        chk("acq_pix_count", pv_cnt, 0);
        for (int f = 0; f < 3; f++) begin
            pv_cnt = 0;
            frame(VT, -1, (f == 0) ? 1 : 0);
            settle("lock");
            chk("lock_pix_count", pv_cnt, HA * VA);
            chk("lock_last_x", last_x, HA - 1);
            chk("lock_last_y", last_y, VA - 1);
        end

        // Short line while locked: h_err now, lock held until frame end.
        frame(VT, 4, 0);
        settle("short_line");
        chk("short_line_locked_held", int'(locked), 1);
        frame(VT, -1, 0);
        settle("after_bad_frame");

        // Short frame while acquiring, then a good one locks without done.
        frame(VT - 1, -1, 0);
        settle("acq_short");
        frame(VT, -1, 0);
        settle("acq_retry");
        frame(VT, -1, 0);
        settle("relocked");

        // Reset mid-frame while locked.
        frame(5, -1, 0);
        settle("pre_rst");
        @(negedge clk);
        rst = 1'b1;
        #1 check_zero("rst_mid");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("rst_mid_hold");
        rst = 1'b0;
        model_reset();
        frame(VT, -1, 0);
        settle("rst_edge1");
        chk("rst_edge1_unlocked", int'(locked), 0);
        frame(VT, -1, 0);
        settle("rst_edge2");

        // Many bad frames saturate the error counter.
        for (int f = 0; f < 301; f++) frame(2, -1, 0);
        settle("sat");
        chk("err_saturated", int'(err_cnt), 255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule

// File: doc/vga_sync_monitor.md
VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 The block SHALL use one clock, clk; reset rst is asynchronous and active-high.
REQ-002 Parameters (name, default, meaning) SHALL be:
- H_TOTAL, 800, pixels per line.
- H_START, 144, first active h_cnt (sync plus back porch).
- H_ACTIVE, 640, active pixels per line.
- V_TOTAL, 525, lines per frame.
- V_START, 35, first active v_cnt.
- V_ACTIVE, 480, active lines.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- pix_en, in, 1, pixel-rate enable; all sampling and counting occurs only on pix_en cycles.
- Hsync, in, 1, active-low horizontal sync from the display generator.
- Vsync, in, 1, active-low vertical sync.
- ColorIn, in, 8, pixel colour.
- locked, out, 1, timing verified.
- pix_valid, out, 1, active pixel strobe.
- pix_x, out, 10, active column.
- pix_y, out, 10, active row.
- pix_data, out, 8, captured colour.
- frame_done, out, 1, one-cycle pulse per verified frame.
- frame_sum, out, 16, checksum of the last verified frame.
- h_err, out, 1, one-cycle pulse on a bad line length.
- v_err, out, 1, one-cycle pulse on a bad frame length.
- err_cnt, out, 8, saturating error count.

Function
REQ-004 Hsync, Vsync and ColorIn SHALL be registered on pix_en cycles; edge detection SHALL compare the registered sample with the previous one, and a falling edge is a 1-to-0 transition.
REQ-005 h_cnt (10 bit) SHALL load 0 on the sample containing an Hsync falling edge, otherwise increment per pix_en, saturating at 1023.
REQ-006 On each Hsync falling edge outside HUNT, if the pre-edge h_cnt is not H_TOTAL-1, the block SHALL pulse h_err.
REQ-007 line_cnt SHALL load 0 on a Vsync falling edge, or 1 if an Hsync falling edge is in the same sample; otherwise it SHALL increment on each Hsync falling edge, saturating at 1023.
REQ-008 v_cnt SHALL follow the same rule as line_cnt and SHALL be used for position.
REQ-009 On a Vsync falling edge outside HUNT, a frame is bad if the pre-edge line_cnt is not V_TOTAL or any h_err occurred since the previous Vsync falling edge.
REQ-010 The state machine SHALL have three states:
- HUNT (reset state): first Vsync falling edge goes to ACQUIRE.
- ACQUIRE: at the next Vsync falling edge, a good frame goes to LOCKED, a bad frame pulses v_err and stays in ACQUIRE.
- LOCKED: a good frame pulses frame_done; a bad frame pulses v_err, clears locked and goes to HUNT.
REQ-011 locked SHALL be 1 exactly in LOCKED.
REQ-012 An h_err in LOCKED SHALL NOT leave LOCKED before the Vsync edge ends that frame.
REQ-013 The pixel is active when h_cnt is in [H_START, H_START+H_ACTIVE-1] and v_cnt is in [V_START, V_START+V_ACTIVE-1].
REQ-014 In LOCKED, pix_valid SHALL assert for an active pixel, with pix_x = h_cnt-H_START, pix_y = v_cnt-V_START and pix_data = that sample's ColorIn.
REQ-015 pix_valid, pix_x, pix_y and pix_data SHALL be registered outputs appearing exactly 2 clk cycles after the pix_en cycle on which ColorIn was presented; pix_valid is a single-clk pulse.
REQ-016 The accumulator SHALL add every active ColorIn (zero-extended, mod 2^16) in ACQUIRE and LOCKED, and SHALL clear at each Vsync falling edge.
REQ-017 frame_sum SHALL load the accumulator total in the same cycle frame_done pulses and SHALL otherwise hold.
REQ-018 err_cnt SHALL increment by 1 per clk in which h_err or v_err pulses, including both together, and SHALL saturate at 255.
REQ-019 Without pix_en all state SHALL hold, and pulse outputs SHALL be 0.

Reset
REQ-020 While rst=1 the block SHALL enter HUNT asynchronously, with all counters and registered samples at 0, and Hsync/Vsync samples at 1.
REQ-021 While rst=1 all outputs SHALL be 0.
REQ-022 Reset mid-frame SHALL discard the partial frame; relock SHALL require a fresh Vsync edge followed by one good frame.

Verification
REQ-023 A bench SHALL drive nominal 800x525 timing with pix_en every 2nd clk -> locked=1 after the 2nd Vsync falling edge; frame_done pulses at the 3rd; pix_valid occurs 307200 times per frame; first is (0,0), last is (639,479).
REQ-024 A bench SHALL drive ColorIn = (h_cnt+v_cnt) mod 256 -> pix_data matches 2 clk after each sample; frame_sum equals the model's mod-2^16 sum.
REQ-025 A bench SHALL shorten one line to 799 while LOCKED -> h_err pulse; err_cnt=1; locked stays 1 until that frame's Vsync edge; then v_err, err_cnt=2, HUNT.
REQ-026 A bench SHALL drive a 524-line frame in ACQUIRE -> v_err; stays ACQUIRE; next good frame -> locked=1 without frame_done.
REQ-027 A bench SHALL assert rst for 3 clk mid-frame while LOCKED -> all outputs 0 immediately; locked returns only after two further Vsync falling edges.
REQ-028 A bench SHALL force 300 bad frames -> err_cnt saturates at 255.
